// File: rtl/mul_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : mul_accumulator
//  Description : MAC back end. It accumulates a programmed number of signed
//                2*WIDTH-bit products into an ACC_W-bit running sum. Products
//                arrive on a valid/ready stream, and each job produces one
//                result beat on a valid/ready output.
//  Config macro: ACC_SATURATE_EN
//                  defined   -> the sum clamps to the signed ACC_W limits on
//                               overflow
//                  undefined -> two's-complement wrap modulo 2^ACC_W
//                The sticky overflow flag behaves the same in both builds.
//  Ports       :
//    clk        in   1        clock, rising edge
//    rst_n      in   1        asynchronous active-low reset
//    start      in   1        begin a job (sampled only in IDLE)
//    count      in   CNT_W    products in the job, latched on start
//    in_prod    in   2*WIDTH  two's-complement product
//    in_valid   in   1        in_prod valid
//    in_ready   out  1        accumulator accepts in_prod (ACCUM state)
//    acc_out    out  ACC_W    registered signed accumulator value
//    out_valid  out  1        acc_out holds the final job result
//    out_ready  in   1        downstream accepts the result
//    busy       out  1        state != IDLE
//    overflow   out  1        sticky signed overflow for the current job
//  Revision    : 1.0  initial release
// ============================================================================
module mul_accumulator #(
  parameter int WIDTH = 6,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     count,
  input  logic [2*WIDTH-1:0]   in_prod,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_W-1:0]     acc_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 overflow
);

  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               overflow_q,  overflow_d;

  // The sum is formed one bit wider than the accumulator. The top two bits
  // then show whether the true signed result is outside the ACC_W range.
  logic [ACC_W:0]     prod_ext;
  logic [ACC_W:0]     sum_wide;
  logic               sum_ovf;
  logic [ACC_W-1:0]   sum_next;
  logic               xfer;

  assign prod_ext = {{(ACC_W + 1 - PROD_W){in_prod[PROD_W-1]}}, in_prod};
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + prod_ext;
  assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

`ifdef ACC_SATURATE_EN
  // The true sign (the extra MSB) selects which limit to clamp to. A clamped
  // value stays clamped until an add of the opposite sign pulls it back.
  always_comb begin
    sum_next = sum_wide[ACC_W-1:0];
    if (sum_ovf) begin
      if (sum_wide[ACC_W]) begin
        sum_next = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sum_next = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end
`else
  assign sum_next = sum_wide[ACC_W-1:0];
`endif

  // in_ready is decoded from state only, so it has no path from in_valid.
  assign xfer = (state_q == S_ACCUM) & in_valid;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d       = '0;
          overflow_d  = 1'b0;
          remaining_d = count;
          state_d     = (count == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (xfer) begin
          acc_d       = sum_next;
          overflow_d  = overflow_q | sum_ovf;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // The result stays frozen until it is taken. start is ignored here.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign acc_out   = acc_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire
